// File: rtl/ecc_result_serializer_if.sv
// Word stream from the serializer to its sink.
// A word moves when DOUT_VALID and DOUT_READY are both high.
interface ecc_result_serializer_if;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;
    logic        DOUT_LAST;

    modport master (
        output DOUT,
        output DOUT_VALID,
        output DOUT_LAST,
        input  DOUT_READY
    );

    modport slave (
        input  DOUT,
        input  DOUT_VALID,
        input  DOUT_LAST,
        output DOUT_READY
    );
endinterface

// File: rtl/ecc_result_serializer.sv
// Serializes an affine point (x then y) into 32-bit words, LS word first.
// Defining ECC_RESULT_HEADER_EN adds a header word (0xECC0_0000 | FIELD_W).
module ecc_result_serializer #(
    parameter int FIELD_W = 233
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [FIELD_W-1:0] DINx,
    input  logic [FIELD_W-1:0] DINy,
    input  logic               PM_VALID,
    input  logic               OVR_CLR,
    output logic               BUSY,
    output logic               OVERRUN,
    ecc_result_serializer_if.master bus
);

    localparam int NW = (FIELD_W + 31) / 32;
    localparam int PW = NW * 32;
    localparam int IW = (NW > 8) ? $clog2(NW) : 3;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
`ifdef ECC_RESULT_HEADER_EN
        HDR,
`endif
        SEND_X,
        SEND_Y
    } state_t;

`ifdef ECC_RESULT_HEADER_EN
    localparam state_t START = HDR;
    localparam logic [31:0] HDR_WORD = 32'hECC0_0000 | 32'(FIELD_W);
`else
    localparam state_t START = SEND_X;
`endif

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [FIELD_W-1:0] x_q, y_q;
    logic               overrun;
    logic [PW-1:0]      x_pad, y_pad;
    logic [31:0]        xw [NW];
    logic [31:0]        yw [NW];
    logic               hs, last, final_hs, accept, drop;

    assign x_pad = PW'(x_q);
    assign y_pad = PW'(y_q);

    for (genvar k = 0; k < NW; k++) begin : g_w
        assign xw[k] = x_pad[k*32 +: 32];
        assign yw[k] = y_pad[k*32 +: 32];
    end

    // A word is always on offer outside IDLE, so READY alone marks a transfer.
    assign hs       = (state != IDLE) && bus.DOUT_READY;
    assign last     = (idx == LAST_IDX);
    assign final_hs = hs && (state == SEND_Y) && last;
    assign accept   = PM_VALID && ((state == IDLE) || final_hs);
    assign drop     = PM_VALID && !accept;

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        bus.DOUT       = '0;
        bus.DOUT_VALID = 1'b0;
        bus.DOUT_LAST  = 1'b0;
        BUSY           = 1'b0;
        unique case (state)
            IDLE: begin
                if (PM_VALID) begin
                    state_n = START;
                    idx_n   = '0;
                end
            end
`ifdef ECC_RESULT_HEADER_EN
            HDR: begin
                bus.DOUT       = HDR_WORD;
                bus.DOUT_VALID = 1'b1;
                BUSY           = 1'b1;
                if (hs) begin
                    state_n = SEND_X;
                    idx_n   = '0;
                end
            end
`endif
            SEND_X: begin
                bus.DOUT       = xw[idx];
                bus.DOUT_VALID = 1'b1;
                BUSY           = 1'b1;
                if (hs) begin
                    if (last) begin
                        state_n = SEND_Y;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            SEND_Y: begin
                bus.DOUT       = yw[idx];
                bus.DOUT_VALID = 1'b1;
                bus.DOUT_LAST  = last;
                BUSY           = 1'b1;
                if (hs) begin
                    if (last) begin
                        // Back-to-back result chains straight into the next frame.
                        state_n = PM_VALID ? START : IDLE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            idx     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept) begin
                x_q <= DINx;
                y_q <= DINy;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (OVR_CLR) begin
                overrun <= 1'b0;
            end
        end
    end

    assign OVERRUN = overrun;

endmodule
